// File: rtl/ula_seq.sv
// ula_seq: three-state instruction sequencer feeding an external 8-bit ALU.
// Holds a 4x8 register file, reads operands in EXEC, writes back in WB.
module ula_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  ULAControl,
    output logic [7:0]  scrA,
    output logic [7:0]  scrB,
    input  logic [7:0]  ULAResult,
    input  logic        Z,
    output logic        done,
    output logic        err,
    output logic        z_flag,
    input  logic [1:0]  rd_sel,
    output logic [7:0]  rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] ir;
    logic [7:0]  regs [4];
    logic [7:0]  res_q;
    logic        z_q;

    logic [2:0]  ir_op;
    logic [1:0]  ir_rd;
    logic [1:0]  ir_ra;
    logic [1:0]  ir_rb;
    logic [7:0]  ir_imm;
    logic        ir_is_alu;
    logic        ir_is_li;
    logic        unused_ir_bit12;

    assign ir_op   = ir[15:13];
    assign ir_rd   = ir[11:10];
    assign ir_ra   = ir[9:8];
    assign ir_rb   = ir[7:6];
    assign ir_imm  = ir[7:0];
    assign unused_ir_bit12 = ir[12];

    // Only these op codes may ever reach the ALU; 100/110/111 are handled locally.
    assign ir_is_alu = (ir_op == 3'b000) || (ir_op == 3'b001) || (ir_op == 3'b010) ||
                       (ir_op == 3'b011) || (ir_op == 3'b101);
    assign ir_is_li  = (ir_op == 3'b110);

    assign rd_data = regs[rd_sel];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and control outputs; done/err masked while rst is high
    // so an instruction caught by reset never retires.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        ULAControl  = '0;
        scrA        = '0;
        scrB        = '0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = !rst;
                if (instr_valid && !rst) begin
                    next_state = EXEC;
                end
            end
            EXEC: begin
                if (ir_is_alu) begin
                    ULAControl = ir_op;
                    scrA       = regs[ir_ra];
                    scrB       = regs[ir_rb];
                end
                next_state = WB;
            end
            WB: begin
                done       = !rst;
                err        = !rst && !ir_is_alu && !ir_is_li;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: instruction latch, ALU result capture, register write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            ir     <= '0;
            res_q  <= '0;
            z_q    <= 1'b0;
            z_flag <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir <= instr;
                    end
                end
                EXEC: begin
                    if (ir_is_alu) begin
                        res_q <= ULAResult;
                        z_q   <= Z;
                    end
                end
                WB: begin
                    if (ir_is_alu) begin
                        regs[ir_rd] <= res_q;
                        z_flag      <= z_q;
                    end else if (ir_is_li) begin
                        regs[ir_rd] <= ir_imm;
                        z_flag      <= (ir_imm == 8'h00);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
